// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator driven by one shared counter.
// Period, per-channel duty and alignment mode are double-buffered into
// shadow registers that reload only at a period boundary (or while the block
// is disabled), so a running period is never disturbed by register writes.
//
// Optional feature macro: PWM_CENTER_EN
//   defined   -> center input, dir flop and center-aligned counting compiled in
//   undefined -> edge-aligned only; center input is ignored
module pwm_multi #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N-1:0]          period,
  input  logic [CHANNELS*N-1:0] duty,
  input  logic                  center,
  output logic [CHANNELS-1:0]   out,
  output logic                  sync
);

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [0:0]   DIR_UP   = 1'b0;
  localparam logic [0:0]   DIR_DOWN = 1'b1;

  logic [N-1:0]          cnt_r;
  logic [N-1:0]          ps_r;
  logic [CHANNELS*N-1:0] ds_r;
  logic [CHANNELS-1:0]   out_r;
  logic                  sync_r;

  logic [N-1:0]          cnt_nxt_s;
  logic                  boundary_s;
  logic                  dir_up_s;
  logic [CHANNELS-1:0]   out_nxt_s;
  logic                  sync_nxt_s;

`ifdef PWM_CENTER_EN
  logic [0:0] dir_r;
  logic       cs_r;
  logic [0:0] dir_nxt_s;
  logic       center_mode_s;

  assign dir_up_s      = (dir_r == DIR_UP);
  // Center mode with a zero period degenerates to edge mode.
  assign center_mode_s = cs_r && (ps_r != CNT_ZERO);

  // Counter sequencing: edge ramp 0..Ps, or center triangle 0..Ps-1,Ps-1..0.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    dir_nxt_s  = DIR_UP;
    boundary_s = 1'b0;
    if (center_mode_s) begin
      if (dir_r == DIR_UP) begin
        if (cnt_r == (ps_r - CNT_ONE)) begin
          // Top of the triangle: repeat this value once on the way down.
          cnt_nxt_s = cnt_r;
          dir_nxt_s = DIR_DOWN;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          dir_nxt_s = DIR_UP;
        end
      end else begin
        if (cnt_r == CNT_ZERO) begin
          boundary_s = 1'b1;
          cnt_nxt_s  = CNT_ZERO;
          dir_nxt_s  = DIR_UP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
          dir_nxt_s = DIR_DOWN;
        end
      end
    end else begin
      if (cnt_r == ps_r) begin
        boundary_s = 1'b1;
        cnt_nxt_s  = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
      dir_nxt_s = DIR_UP;
    end
  end

  // Direction and mode shadow: reset/disable park them in up, live mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r <= DIR_UP;
      cs_r  <= 1'b0;
    end else if (!ena) begin
      dir_r <= DIR_UP;
      cs_r  <= center;
    end else begin
      dir_r <= dir_nxt_s;
      if (boundary_s) begin
        cs_r <= center;
      end else begin
        cs_r <= cs_r;
      end
    end
  end
`else
  logic center_unused_s;

  // Edge-only build: the mode input has no effect.
  assign center_unused_s = center;
  assign dir_up_s        = 1'b1;

  // Counter sequencing: edge ramp 0..Ps then wrap.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    boundary_s = 1'b0;
    if (cnt_r == ps_r) begin
      boundary_s = 1'b1;
      cnt_nxt_s  = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end
`endif

  // Per-channel compare; an all-ones duty is pinned high at any period.
  always_comb begin
    out_nxt_s = {CHANNELS{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      out_nxt_s[ch] = (cnt_r < ds_r[ch*N +: N]) || (ds_r[ch*N +: N] == CNT_MAX);
    end
    sync_nxt_s = (cnt_r == CNT_ZERO) && dir_up_s;
  end

  // Counter, period/duty shadows and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= CNT_ZERO;
      ps_r   <= CNT_ZERO;
      ds_r   <= {(CHANNELS*N){1'b0}};
      out_r  <= {CHANNELS{1'b0}};
      sync_r <= 1'b0;
    end else if (!ena) begin
      // Disabled: hold at period start and keep shadows tracking live inputs.
      cnt_r  <= CNT_ZERO;
      ps_r   <= period;
      ds_r   <= duty;
      out_r  <= {CHANNELS{1'b0}};
      sync_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      out_r  <= out_nxt_s;
      sync_r <= sync_nxt_s;
      if (boundary_s) begin
        ps_r <= period;
        ds_r <= duty;
      end else begin
        ps_r <= ps_r;
        ds_r <= ds_r;
      end
    end
  end

  assign out  = out_r;
  assign sync = sync_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: the stimulus process pushes the expected
// {out,sync} for every upcoming clock edge; a monitor pops and compares just
// after each rising edge.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        center;
  logic [7:0]  period;
  logic [7:0]  d0, d1, d2, d3;
  logic [31:0] duty;
  logic [3:0]  out;
  logic        sync;

  logic [4:0]  exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          idx      = 0;

  assign duty = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  pwm_multi #(.N(8), .CHANNELS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .period (period),
    .duty   (duty),
    .center (center),
    .out    (out),
    .sync   (sync)
  );

  // Queue the expectation for the next rising edge, then move to the next negedge.
  task automatic cyc(input logic [3:0] eo, input logic es);
    exp_q.push_back({eo, es});
    @(negedge clk);
  endtask

  // Immediate (non-scoreboard) comparison of the current outputs.
  task automatic check_now(input string name, input logic [3:0] eo, input logic es);
    checks++;
    if (out !== eo || sync !== es) begin
      failures++;
      $display("FAIL %s got out=%b sync=%b expected out=%b sync=%b", name, out, sync, eo, es);
    end
  endtask

  // Hand pattern: out3/out2 high, out1 low; out0 from the duty window.
  task automatic run(input int plen, input int hi, input bit ctr, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      int  kk;
      bit  o0;
      kk = k % plen;
      if (ctr) o0 = (kk < hi) || (kk >= plen - hi);
      else     o0 = (kk < hi);
      cyc({1'b1, 1'b1, 1'b0, o0}, kk == 0);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({out, sync} !== e) begin
          failures++;
          $display("FAIL sb_edge idx=%0d got out=%b sync=%b expected out=%b sync=%b",
                   idx, out, sync, e[4:1], e[0]);
        end
        idx++;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0; ena = 1'b0; center = 1'b0; period = 8'd0;
    d0 = 8'h80; d1 = 8'h80; d2 = 8'h80; d3 = 8'h80;
    @(negedge clk);
    check_now("reset_state", 4'b0000, 1'b0);
    repeat (3) cyc(4'b0000, 1'b0);
    rst = 1'b1;
    repeat (2) cyc(4'b0000, 1'b0);

    // Edge mode P=9, D={255,10,0,3}; shadows loaded while disabled.
    period = 8'd9; d0 = 8'd3; d1 = 8'd0; d2 = 8'd10; d3 = 8'd255;
    cyc(4'b0000, 1'b0);
    ena = 1'b1;
    run(10, 3, 1'b0, 0, 30);

    // Double buffering: mid-period change takes effect at next boundary.
    run(10, 3, 1'b0, 0, 2);
    d0 = 8'd7; period = 8'd4;
    run(10, 3, 1'b0, 2, 8);
    run(5, 5, 1'b0, 0, 10);
    period = 8'd0; d0 = 8'd1;
    run(5, 5, 1'b0, 0, 5);

    // P=0: one-cycle period, sync every cycle.
    run(1, 1, 1'b0, 0, 4);
    d0 = 8'd0;
    run(1, 1, 1'b0, 0, 1);
    run(1, 0, 1'b0, 0, 4);

    // Center request with P=4, D0=2.
    center = 1'b1; period = 8'd4; d0 = 8'd2;
    run(1, 0, 1'b0, 0, 1);
`ifdef PWM_CENTER_EN
    run(8, 2, 1'b1, 0, 8);
    run(8, 2, 1'b1, 0, 3);
    d0 = 8'd4;
    run(8, 2, 1'b1, 3, 5);
    center = 1'b0; period = 8'd9; d0 = 8'd3;
    run(8, 4, 1'b1, 0, 8);
`else
    run(5, 2, 1'b0, 0, 5);
    center = 1'b0; period = 8'd9; d0 = 8'd3;
    run(5, 2, 1'b0, 0, 5);
`endif

    // ena dropped mid-period, then restarted with a full period.
    run(10, 3, 1'b0, 0, 4);
    ena = 1'b0;
    repeat (3) cyc(4'b0000, 1'b0);
    ena = 1'b1;
    run(10, 3, 1'b0, 0, 10);

    // rst pulsed mid-period: outputs drop immediately.
    run(10, 3, 1'b0, 0, 5);
    rst = 1'b0;
    #1;
    check_now("rst_async_drop", 4'b0000, 1'b0);
    repeat (2) cyc(4'b0000, 1'b0);
    rst = 1'b1; ena = 1'b0;
    cyc(4'b0000, 1'b0);
    ena = 1'b1;
    run(10, 3, 1'b0, 0, 10);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
